// File: rtl/rv_arb_pkg.sv
// Shared types and widths for the RISC-V SDRAM channel arbiter.
package rv_arb_pkg;
  localparam int RV_AW     = 20;
  localparam int RV_DW     = 16;
  localparam int MAX_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rv_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr_i, ascending with wrap.
module rv_rr_pick #(
  parameter int NPORTS = 3
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [1:0]        ptr_i,
  output logic [1:0]        idx_o,
  output logic              vld_o
);
  int j;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    idx_o = 2'd0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NPORTS) j = j - NPORTS;
      if (req_i[j]) begin
        idx_o = 2'(j);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares the RV SDRAM channel (toggle req/ack) among NPORTS requesters, one access at a time.
// Define RV_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest); default is round-robin.
module rv_mem_arbiter
  import rv_arb_pkg::*;
#(
  parameter int NPORTS = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    busy,
  input  logic [NPORTS-1:0]       m_req,
  input  logic [NPORTS-1:0]       m_we,
  input  logic [NPORTS*RV_AW-1:0] m_addr,
  input  logic [NPORTS*RV_DW-1:0] m_din,
  input  logic [NPORTS*2-1:0]     m_ds,
  output logic [NPORTS-1:0]       m_ack,
  output logic [RV_DW-1:0]        m_rdata,
  output logic [1:0]              grant_id,
  output logic [RV_AW-1:0]        rv_addr,
  output logic [RV_DW-1:0]        rv_din,
  output logic [1:0]              rv_ds,
  output logic                    rv_we,
  output logic                    rv_req,
  input  logic                    rv_req_ack,
  input  logic [RV_DW-1:0]        rv_dout
);
  arb_state_e        state_q, state_d;
  logic              rv_req_q, rv_req_d;
  logic [RV_AW-1:0]  rv_addr_q, rv_addr_d;
  logic [RV_DW-1:0]  rv_din_q, rv_din_d;
  logic [1:0]        rv_ds_q, rv_ds_d;
  logic              rv_we_q, rv_we_d;
  logic [NPORTS-1:0] m_ack_q, m_ack_d;
  logic [RV_DW-1:0]  m_rdata_q, m_rdata_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        pick_ptr, pick_idx;
  logic              pick_vld;
  int                sel;

`ifdef RV_ARB_FIXED_PRIO_EN
  assign pick_ptr = 2'd0;
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;

  assign pick_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == DATA)
      rr_ptr_d = (grant_q == 2'(NPORTS - 1)) ? 2'd0 : grant_q + 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr_q <= 2'd0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  rv_rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req_i (m_req),
    .ptr_i (pick_ptr),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    rv_req_d  = rv_req_q;
    rv_addr_d = rv_addr_q;
    rv_din_d  = rv_din_q;
    rv_ds_d   = rv_ds_q;
    rv_we_d   = rv_we_q;
    m_ack_d   = '0;
    m_rdata_d = m_rdata_q;
    grant_d   = grant_q;
    sel       = int'(pick_idx);
    unique case (state_q)
      // No grant during an m_ack cycle: the acked port's m_req still belongs to
      // the finished access, and its re-request must compete on equal terms.
      IDLE: begin
        if (!busy && (rv_req_q == rv_req_ack) && (m_ack_q == '0) && pick_vld) begin
          grant_d   = pick_idx;
          rv_addr_d = m_addr[sel*RV_AW +: RV_AW];
          rv_din_d  = m_din[sel*RV_DW +: RV_DW];
          rv_ds_d   = m_ds[sel*2 +: 2];
          rv_we_d   = m_we[sel];
          rv_req_d  = ~rv_req_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (rv_req_ack == rv_req_q) state_d = DATA;
      end
      DATA: begin
        if (!rv_we_q) m_rdata_d = rv_dout;
        m_ack_d[grant_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rv_req_q  <= 1'b0;
      rv_addr_q <= '0;
      rv_din_q  <= '0;
      rv_ds_q   <= '0;
      rv_we_q   <= 1'b0;
      m_ack_q   <= '0;
      m_rdata_q <= '0;
      grant_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      rv_req_q  <= rv_req_d;
      rv_addr_q <= rv_addr_d;
      rv_din_q  <= rv_din_d;
      rv_ds_q   <= rv_ds_d;
      rv_we_q   <= rv_we_d;
      m_ack_q   <= m_ack_d;
      m_rdata_q <= m_rdata_d;
      grant_q   <= grant_d;
    end
  end

  assign rv_req   = rv_req_q;
  assign rv_addr  = rv_addr_q;
  assign rv_din   = rv_din_q;
  assign rv_ds    = rv_ds_q;
  assign rv_we    = rv_we_q;
  assign m_ack    = m_ack_q;
  assign m_rdata  = m_rdata_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: randomised requesters and controller model, grant/data scoreboard.
module tb_rv_mem_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn = 1'b0, busy = 1'b1;
  logic [N-1:0]    m_req = '0, m_we = '0;
  logic [N*20-1:0] m_addr = '0;
  logic [N*16-1:0] m_din = '0;
  logic [N*2-1:0]  m_ds = '0;
  logic [N-1:0]    m_ack;
  logic [15:0]     m_rdata;
  logic [1:0]      grant_id;
  logic [19:0]     rv_addr;
  logic [15:0]     rv_din;
  logic [1:0]      rv_ds;
  logic            rv_we, rv_req;
  logic            rv_req_ack = 1'b0;
  logic [15:0]     rv_dout = '0;

  rv_mem_arbiter #(.NPORTS(N)) dut (
    .clk(clk), .resetn(resetn), .busy(busy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_ds(m_ds),
    .m_ack(m_ack), .m_rdata(m_rdata), .grant_id(grant_id),
    .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we),
    .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout)
  );

  int tests = 0, fails = 0, cyc = 0, toggles = 0;
  int ack_cnt[N];
  logic [1:0] grant_log[$];

  // requester knobs
  logic [N-1:0] port_en = '0, rnd_en = '1;
  logic         rnd_we = 1'b0;
  logic [19:0]  f_addr[N];
  logic [15:0]  f_din[N];
  logic [1:0]   f_ds[N];
  logic         f_we[N];
  bit           ackd[N];

  // controller model knobs/state
  bit ctl_auto = 1'b1, ctl_force = 1'b0, ctl_pend = 1'b0;
  int ctl_cnt = 0, ctl_dly = 0, ctl_fix = 0;

  // reference model state
  logic [N-1:0]    s_req, s_we;
  logic [N*20-1:0] s_addr;
  logic [N*16-1:0] s_din;
  logic [N*2-1:0]  s_ds;
  logic            s_busy, s_ack;
  logic            prev_rv_req = 1'b0;
  logic [N-1:0]    prev_mack = '0;
  bit              inflight = 1'b0;
  int              ptr = 0, g_cyc = 0;
  logic [1:0]      g_port;
  logic [19:0]     g_addr;
  logic [15:0]     g_din;
  logic [1:0]      g_ds;
  logic            g_we;
  logic [15:0]     exp_rdata = '0;

  // inputs as the DUT sees them at the active edge
  always @(posedge clk) begin
    s_req = m_req; s_we = m_we; s_addr = m_addr; s_din = m_din; s_ds = m_ds;
    s_busy = busy; s_ack = rv_req_ack;
  end

  always @(negedge clk) begin
    int exp_p;
    cyc++;
    // requesters: after an ack, change m_req only one cycle later
    for (int i = 0; i < N; i++) begin
      if (ackd[i] || !m_req[i]) begin
        ackd[i] = 1'b0;
        if (port_en[i]) begin
          m_req[i] = 1'b1;
          if (rnd_en[i]) begin
            m_addr[i*20 +: 20] = 20'($urandom);
            m_din[i*16 +: 16]  = 16'($urandom);
            m_ds[i*2 +: 2]     = 2'($urandom_range(1, 3));
            m_we[i]            = rnd_we ? 1'($urandom_range(0, 1)) : 1'b0;
          end else begin
            m_addr[i*20 +: 20] = f_addr[i];
            m_din[i*16 +: 16]  = f_din[i];
            m_ds[i*2 +: 2]     = f_ds[i];
            m_we[i]            = f_we[i];
          end
        end else begin
          m_req[i] = 1'b0;
        end
      end
    end
    if (!resetn) begin
      inflight = 1'b0; ptr = 0; prev_rv_req = 1'b0; prev_mack = '0; exp_rdata = '0;
      ctl_pend = 1'b0;
    end else begin
      if (rv_req !== prev_rv_req) begin
        tests++;
        if (inflight || s_busy || (prev_rv_req !== s_ack) || (prev_mack != '0)) begin
          fails++;
          $display("FAIL grant_cond: inflight=%0d busy=%b rv_req=%b ack=%b m_ack=%b, need idle/busy0/req==ack/no ack",
                   inflight, s_busy, prev_rv_req, s_ack, prev_mack);
        end
        exp_p = -1;
        for (int k = 0; k < N; k++)
          if (exp_p < 0 && s_req[(ptr + k) % N]) exp_p = (ptr + k) % N;
        tests++;
        if (exp_p < 0 || grant_id !== 2'(exp_p)) begin
          fails++;
          $display("FAIL grant_id: got %0d expected %0d (req=%b ptr=%0d)", grant_id, exp_p, s_req, ptr);
        end else begin
          tests++;
          if ({rv_addr, rv_din, rv_ds, rv_we} !== {s_addr[exp_p*20 +: 20], s_din[exp_p*16 +: 16],
                                                   s_ds[exp_p*2 +: 2], s_we[exp_p]}) begin
            fails++;
            $display("FAIL rv_fields: got a=%h d=%h ds=%b we=%b expected a=%h d=%h ds=%b we=%b",
                     rv_addr, rv_din, rv_ds, rv_we, s_addr[exp_p*20 +: 20], s_din[exp_p*16 +: 16],
                     s_ds[exp_p*2 +: 2], s_we[exp_p]);
          end
        end
        inflight = 1'b1; g_port = grant_id; g_addr = rv_addr; g_din = rv_din; g_ds = rv_ds;
        g_we = rv_we; g_cyc = cyc; toggles++; grant_log.push_back(grant_id);
      end else if (inflight) begin
        tests++;
        if ({rv_addr, rv_din, rv_ds, rv_we} !== {g_addr, g_din, g_ds, g_we}) begin
          fails++;
          $display("FAIL rv_stable: got a=%h d=%h ds=%b we=%b expected a=%h d=%h ds=%b we=%b",
                   rv_addr, rv_din, rv_ds, rv_we, g_addr, g_din, g_ds, g_we);
        end
      end
      if (m_ack != '0) begin
        tests++;
        if (!inflight || m_ack !== (N'(1) << g_port)) begin
          fails++;
          $display("FAIL ack: got m_ack=%b inflight=%0d expected one pulse for port %0d", m_ack, inflight, g_port);
        end else begin
          tests++;
          if (cyc - g_cyc != ctl_dly + 2) begin
            fails++;
            $display("FAIL ack_latency: got %0d cycles expected %0d", cyc - g_cyc, ctl_dly + 2);
          end
          if (!g_we) exp_rdata = g_addr[15:0] ^ 16'hA5A5;
          inflight = 1'b0;
`ifdef RV_ARB_FIXED_PRIO_EN
          ptr = 0;
`else
          ptr = (int'(g_port) + 1) % N;
`endif
          ack_cnt[g_port]++;
          ackd[g_port] = 1'b1;
        end
      end
      tests++;
      if (m_rdata !== exp_rdata) begin
        fails++;
        $display("FAIL rdata: got %h expected %h", m_rdata, exp_rdata);
      end
      prev_rv_req = rv_req; prev_mack = m_ack;
    end
    // SDRAM controller model
    if (!ctl_auto) rv_req_ack = ctl_force;
    else if (resetn && rv_req != rv_req_ack) begin
      if (!ctl_pend) begin
        ctl_pend = 1'b1;
        ctl_dly  = (ctl_fix > 0) ? ctl_fix : int'($urandom_range(4, 12));
        ctl_cnt  = ctl_dly;
      end else begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          rv_req_ack = rv_req;
          rv_dout    = rv_addr[15:0] ^ 16'hA5A5;
          ctl_pend   = 1'b0;
        end
      end
    end
  end

  task automatic quiesce();
    int c;
    port_en = '0;
    for (c = 0; c < 500 && (inflight || m_req != '0 || m_ack != '0); c++) @(negedge clk);
    tests++;
    if (c >= 500) begin fails++; $display("FAIL quiesce: timeout, m_req=%b inflight=%0d", m_req, inflight); end
  endtask

  task automatic check_reset_outputs(input string nm);
    tests++;
    if ({rv_req, rv_addr, rv_din, rv_ds, rv_we, m_ack, m_rdata, grant_id} !== '0) begin
      fails++;
      $display("FAIL %s: got req=%b a=%h d=%h ds=%b we=%b ack=%b rd=%h gid=%0d expected all 0",
               nm, rv_req, rv_addr, rv_din, rv_ds, rv_we, m_ack, m_rdata, grant_id);
    end
  endtask

  task automatic test_reset();
    int t0, c;
    grant_log.delete();
    resetn = 1'b0; busy = 1'b1; rnd_we = 1'b0; port_en = '1;
    #1;
    check_reset_outputs("reset_values");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    t0 = toggles;
    repeat (20) @(negedge clk);
    tests++;
    if (toggles != t0) begin fails++; $display("FAIL busy_hold: got %0d toggles expected 0", toggles - t0); end
    busy = 1'b0;
    for (c = 0; c < 50 && toggles == t0; c++) @(negedge clk);
    tests++;
    if (toggles == t0) begin fails++; $display("FAIL first_grant: timeout, no grant"); end
    else begin
      tests++;
      if (grant_log[0] !== 2'd0) begin fails++; $display("FAIL first_port: got %0d expected 0", grant_log[0]); end
    end
  endtask

  task automatic test_round_robin();
    int c;
    logic [1:0] e;
    for (c = 0; c < 1000 && grant_log.size() < 6; c++) @(negedge clk);
    tests++;
    if (grant_log.size() < 6) begin fails++; $display("FAIL rr_timeout: got %0d grants expected 6", grant_log.size()); end
    else for (int i = 0; i < 6; i++) begin
`ifdef RV_ARB_FIXED_PRIO_EN
      e = 2'd0;
`else
      e = 2'(i % 3);
`endif
      tests++;
      if (grant_log[i] !== e) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_log[i], e); end
    end
    quiesce();
  endtask

  task automatic test_write();
    int t0, a0, c;
    logic [15:0] rd0;
    f_addr[1] = 20'h01234; f_din[1] = 16'hBEEF; f_ds[1] = 2'b01; f_we[1] = 1'b1; rnd_en[1] = 1'b0;
    t0 = toggles; a0 = ack_cnt[1]; rd0 = m_rdata;
    port_en[1] = 1'b1;
    @(negedge clk);
    port_en[1] = 1'b0;
    for (c = 0; c < 100 && ack_cnt[1] == a0; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    tests++;
    if ({rv_addr, rv_din, rv_ds, rv_we} !== {20'h01234, 16'hBEEF, 2'b01, 1'b1}) begin
      fails++;
      $display("FAIL write_fields: got a=%h d=%h ds=%b we=%b expected 01234/BEEF/01/1", rv_addr, rv_din, rv_ds, rv_we);
    end
    tests++;
    if (toggles - t0 != 1) begin fails++; $display("FAIL write_toggles: got %0d expected 1", toggles - t0); end
    tests++;
    if (ack_cnt[1] - a0 != 1) begin fails++; $display("FAIL write_acks: got %0d expected 1", ack_cnt[1] - a0); end
    tests++;
    if (m_rdata !== rd0) begin fails++; $display("FAIL write_rdata: got %h expected %h", m_rdata, rd0); end
    rnd_en[1] = 1'b1;
  endtask

  task automatic test_slow_ack();
    int t0, a0, c;
    ctl_fix = 50; t0 = toggles; a0 = ack_cnt[2];
    port_en[2] = 1'b1;
    @(negedge clk);
    port_en[2] = 1'b0;
    for (c = 0; c < 200 && ack_cnt[2] == a0; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    tests++;
    if (toggles - t0 != 1) begin fails++; $display("FAIL slow_toggles: got %0d expected 1", toggles - t0); end
    tests++;
    if (ack_cnt[2] - a0 != 1) begin fails++; $display("FAIL slow_acks: got %0d expected 1", ack_cnt[2] - a0); end
    ctl_fix = 0;
  endtask

  task automatic test_reset_mid();
    int t0, c;
    ctl_fix = 30;
    port_en[0] = 1'b1;
    @(negedge clk);
    port_en[0] = 1'b0;
    for (c = 0; c < 50 && !inflight; c++) @(negedge clk);
    tests++;
    if (!inflight) begin fails++; $display("FAIL mid_start: timeout, no grant"); end
    repeat (5) @(negedge clk);
    #2;
    ctl_auto = 1'b0; ctl_force = 1'b1; resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset_values");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t0 = toggles;
    repeat (20) @(negedge clk);
    tests++;
    if (toggles != t0) begin fails++; $display("FAIL stale_ack: got %0d grants expected 0", toggles - t0); end
    ctl_fix = 0; ctl_auto = 1'b1;
    for (c = 0; c < 50 && toggles == t0; c++) @(negedge clk);
    tests++;
    if (toggles == t0) begin fails++; $display("FAIL resync_grant: timeout, no grant"); end
    else begin
      tests++;
      if (grant_log[$] !== 2'd0) begin fails++; $display("FAIL resync_port: got %0d expected 0", grant_log[$]); end
    end
    quiesce();
  endtask

  task automatic test_random_busy();
    int t0, a0;
    t0 = toggles; a0 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2];
    rnd_we = 1'b1; port_en = '1;
    repeat (600) begin
      @(negedge clk);
      busy = ($urandom_range(0, 5) == 0);
    end
    busy = 1'b0;
    quiesce();
    tests++;
    if (ack_cnt[0] + ack_cnt[1] + ack_cnt[2] - a0 != toggles - t0 || toggles == t0) begin
      fails++;
      $display("FAIL random_balance: got %0d acks for %0d grants", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] - a0, toggles - t0);
    end
    rnd_we = 1'b0;
  endtask

  task automatic test_prio();
    int a0, a2, c;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    a0 = ack_cnt[0]; a2 = ack_cnt[2];
    port_en = 3'b101;
    for (c = 0; c < 1000 && (ack_cnt[0] - a0) + (ack_cnt[2] - a2) < 8; c++) @(negedge clk);
    tests++;
    if ((ack_cnt[0] - a0) + (ack_cnt[2] - a2) < 8) begin fails++; $display("FAIL prio_timeout: fewer than 8 acks"); end
    tests++;
`ifdef RV_ARB_FIXED_PRIO_EN
    if (ack_cnt[2] != a2) begin fails++; $display("FAIL prio_port2: got %0d grants expected 0", ack_cnt[2] - a2); end
`else
    if (ack_cnt[2] - a2 < 3) begin fails++; $display("FAIL rr_port2: got %0d grants expected at least 3", ack_cnt[2] - a2); end
`endif
    quiesce();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_slow_ack();
    test_reset_mid();
    test_random_busy();
    test_prio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
